// File: rtl/if_id_pkg.sv
// Shared constants, entry type and counter helper for the IF/ID pipeline register.
package if_id_pkg;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;

  // Default-width entry; the top re-declares it at its own parameterised widths.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
  } if_id_entry_t;

  // Saturating add; max is the all-ones value of the destination counter.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, max}) begin
      return max;
    end
    return sum[31:0];
  endfunction

endpackage

// File: rtl/if_id_pipe_reg_if.sv
// Fetch-side and decode-side handshake bundle for the IF/ID pipeline register.
interface if_id_pipe_reg_if #(
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned CNT_W   = 16
) ();

  logic               if_valid;
  logic               if_ready;
  logic [INSTR_W-1:0] if_instr;
  logic [ADDR_W-1:0]  if_pc_plus4;
  logic               flush;
  logic               id_valid;
  logic               id_ready;
  logic [INSTR_W-1:0] id_instr;
  logic [ADDR_W-1:0]  id_pc_plus4;
  logic [5:0]         id_opcode;
  logic [CNT_W-1:0]   flush_cnt;

  // Environment side: fetch, decode and hazard unit.
  modport master (
    output if_valid, if_instr, if_pc_plus4, flush, id_ready,
    input  if_ready, id_valid, id_instr, id_pc_plus4, id_opcode, flush_cnt
  );

  // Pipeline register side.
  modport slave (
    input  if_valid, if_instr, if_pc_plus4, flush, id_ready,
    output if_ready, id_valid, id_instr, id_pc_plus4, id_opcode, flush_cnt
  );

endinterface

// File: rtl/if_id_entry_reg.sv
// One valid bit plus payload; clear wins over load.
module if_id_entry_reg
  import if_id_pkg::*;
#(
  parameter type entry_t = if_id_entry_t
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   load_i,
  input  logic   clr_i,
  input  entry_t data_i,
  output logic   valid_o,
  output entry_t data_o
);

  logic   valid_d, valid_q;
  entry_t data_d, data_q;

  // Next-state: payload only changes on load, so it stays stale after a clear.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clr_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register: valid/ready handshake, optional skid entry, flush-to-NOP and a
// saturating count of instructions discarded by flush.
module if_id_pipe_reg
  import if_id_pkg::*;
#(
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned SKID    = 1,
  parameter int unsigned CNT_W   = 16
) (
  input logic             clk,
  input logic             rst_n,
  if_id_pipe_reg_if.slave bus
);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc_plus4;
  } entry_t;

  localparam logic [31:0] CntMax = 32'((64'd1 << CNT_W) - 64'd1);

  entry_t in_data, m_data, s_data, m_load_data;
  logic   m_valid, s_valid;
  logic   if_ready, accept, m_free, m_load, m_clr;
  logic   flush;
  logic [31:0]      flush_inc;
  logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;

  assign flush    = bus.flush;
  assign in_data  = '{instr: bus.if_instr, pc_plus4: bus.if_pc_plus4};
  // M can take a new entry when empty or when its current entry leaves this cycle.
  assign m_free   = !m_valid || bus.id_ready;
  assign if_ready = (SKID != 0) ? !s_valid : m_free;
  assign accept   = bus.if_valid && if_ready;

  // S always holds the older entry, so it refills M before any new input.
  assign m_load_data = s_valid ? s_data : in_data;
  assign m_load      = !flush && m_free && (s_valid || accept);
  assign m_clr       = flush || (m_free && !s_valid && !accept);

  if_id_entry_reg #(
    .entry_t (entry_t)
  ) u_main (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (m_load),
    .clr_i   (m_clr),
    .data_i  (m_load_data),
    .valid_o (m_valid),
    .data_o  (m_data)
  );

  if (SKID != 0) begin : g_skid
    logic s_load, s_clr;
    // Only a held M with an accepted input parks data in S.
    assign s_load = !flush && !m_free && accept;
    assign s_clr  = flush || (m_free && s_valid);

    if_id_entry_reg #(
      .entry_t (entry_t)
    ) u_skid (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (s_load),
      .clr_i   (s_clr),
      .data_i  (in_data),
      .valid_o (s_valid),
      .data_o  (s_data)
    );
  end else begin : g_no_skid
    assign s_valid = 1'b0;
    assign s_data  = '0;
  end

  // Discards: M unless it drains this cycle, S, and any accepted input.
  always_comb begin
    flush_inc   = 32'(m_valid && !bus.id_ready) + 32'(s_valid) + 32'(accept);
    flush_cnt_d = flush_cnt_q;
    if (flush) begin
      flush_cnt_d = CNT_W'(sat_add(32'(flush_cnt_q), flush_inc, CntMax));
    end
  end

  // Flush counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_cnt_q <= '0;
    end else begin
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.if_ready    = if_ready;
  assign bus.id_valid    = m_valid;
  assign bus.id_instr    = m_valid ? m_data.instr : INSTR_W'(NOP_INSTR);
  assign bus.id_opcode   = m_valid ? m_data.instr[OPCODE_MSB:OPCODE_LSB] : '0;
  assign bus.id_pc_plus4 = m_data.pc_plus4;
  assign bus.flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Bench for if_id_pipe_reg: three builds (SKID=1, SKID=0, SKID=1 with CNT_W=2) share one
// stimulus stream and are compared every cycle against a FIFO-level reference model.
module tb_if_id_pipe_reg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        if_valid = 1'b0;
  logic        flush = 1'b0;
  logic        id_ready = 1'b0;
  logic [31:0] if_instr = 32'h0;
  logic [31:0] if_pc = 32'h0;

  always #5 clk = ~clk;

  if_id_pipe_reg_if #(.INSTR_W(32), .ADDR_W(32), .CNT_W(16)) bus0 ();
  if_id_pipe_reg_if #(.INSTR_W(32), .ADDR_W(32), .CNT_W(16)) bus1 ();
  if_id_pipe_reg_if #(.INSTR_W(32), .ADDR_W(32), .CNT_W(2))  bus2 ();

  assign bus0.if_valid = if_valid;  assign bus1.if_valid = if_valid;  assign bus2.if_valid = if_valid;
  assign bus0.if_instr = if_instr;  assign bus1.if_instr = if_instr;  assign bus2.if_instr = if_instr;
  assign bus0.if_pc_plus4 = if_pc;  assign bus1.if_pc_plus4 = if_pc;  assign bus2.if_pc_plus4 = if_pc;
  assign bus0.flush = flush;        assign bus1.flush = flush;        assign bus2.flush = flush;
  assign bus0.id_ready = id_ready;  assign bus1.id_ready = id_ready;  assign bus2.id_ready = id_ready;

  if_id_pipe_reg #(.INSTR_W(32), .ADDR_W(32), .SKID(1), .CNT_W(16)) u_dut0 (
    .clk (clk), .rst_n (rst_n), .bus (bus0)
  );
  if_id_pipe_reg #(.INSTR_W(32), .ADDR_W(32), .SKID(0), .CNT_W(16)) u_dut1 (
    .clk (clk), .rst_n (rst_n), .bus (bus1)
  );
  if_id_pipe_reg #(.INSTR_W(32), .ADDR_W(32), .SKID(1), .CNT_W(2)) u_dut2 (
    .clk (clk), .rst_n (rst_n), .bus (bus2)
  );

  logic        d_rdy [3];
  logic        d_vld [3];
  logic [31:0] d_ins [3];
  logic [31:0] d_pc  [3];
  logic [5:0]  d_op  [3];
  logic [15:0] d_cnt [3];

  assign d_rdy[0] = bus0.if_ready;  assign d_rdy[1] = bus1.if_ready;  assign d_rdy[2] = bus2.if_ready;
  assign d_vld[0] = bus0.id_valid;  assign d_vld[1] = bus1.id_valid;  assign d_vld[2] = bus2.id_valid;
  assign d_ins[0] = bus0.id_instr;  assign d_ins[1] = bus1.id_instr;  assign d_ins[2] = bus2.id_instr;
  assign d_pc[0] = bus0.id_pc_plus4; assign d_pc[1] = bus1.id_pc_plus4; assign d_pc[2] = bus2.id_pc_plus4;
  assign d_op[0] = bus0.id_opcode;  assign d_op[1] = bus1.id_opcode;  assign d_op[2] = bus2.id_opcode;
  assign d_cnt[0] = bus0.flush_cnt; assign d_cnt[1] = bus1.flush_cnt;
  assign d_cnt[2] = 16'(bus2.flush_cnt);

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input int i, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s[dut%0d] at %0t: got %0h, expected %0h", nm, i, $time, act, exp);
    end
  endtask

  // Reference model: each build is a FIFO of capacity 2 (skid) or 1 (no skid).
  int unsigned q_n     [3];
  logic [31:0] q_ins   [3][2];
  logic [31:0] q_pc    [3][2];
  int unsigned m_cnt   [3];
  logic [31:0] last_pc [3];

  function automatic bit has_skid(input int i);
    return i != 1;
  endfunction

  function automatic int unsigned cnt_max(input int i);
    return (i == 2) ? 3 : 65535;
  endfunction

  function automatic bit m_rdy(input int i);
    if (has_skid(i)) return q_n[i] < 2;
    return (q_n[i] == 0) || id_ready;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      q_n[i] = 0;
      m_cnt[i] = 0;
      last_pc[i] = 32'h0;
    end
  endtask

  task automatic model_step();
    bit acc, drn;
    int unsigned sum;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 3; i++) begin
      acc = if_valid && m_rdy(i);
      drn = (q_n[i] > 0) && id_ready;
      if (flush) begin
        sum = m_cnt[i] + q_n[i] - int'(drn) + int'(acc);
        m_cnt[i] = (sum > cnt_max(i)) ? cnt_max(i) : sum;
        q_n[i] = 0;
      end else begin
        if (drn) begin
          q_ins[i][0] = q_ins[i][1];
          q_pc[i][0]  = q_pc[i][1];
          q_n[i]--;
        end
        if (acc) begin
          q_ins[i][q_n[i]] = if_instr;
          q_pc[i][q_n[i]]  = if_pc;
          q_n[i]++;
        end
      end
      if (q_n[i] > 0) last_pc[i] = q_pc[i][0];
    end
  endtask

  bit chk_en = 1'b0;

  // Per-cycle comparison of all three builds against the model, away from the clock edge.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        chk("if_ready", i, 32'(d_rdy[i]), 32'(m_rdy(i)));
        chk("id_valid", i, 32'(d_vld[i]), 32'(q_n[i] > 0));
        chk("id_instr", i, d_ins[i], (q_n[i] > 0) ? q_ins[i][0] : 32'h0);
        chk("id_opcode", i, 32'(d_op[i]), (q_n[i] > 0) ? 32'(q_ins[i][0][31:26]) : 32'h0);
        chk("id_pc_plus4", i, d_pc[i], (q_n[i] > 0) ? q_pc[i][0] : last_pc[i]);
        chk("flush_cnt", i, 32'(d_cnt[i]), m_cnt[i]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input logic v, input logic rdy, input logic fl);
    if_valid = v;
    id_ready = rdy;
    flush    = fl;
    if_instr = $urandom;
    if_pc    = $urandom;
  endtask

  logic [31:0] stall_first;

  initial begin
    model_reset();
    #1;
    rst_n = 1'b0;
    if_valid = 1'b1;
    if_instr = 32'hDEAD_BEEF;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_id_valid", 0, 32'(d_vld[0]), 32'h0);
    chk("rst_id_instr", 0, d_ins[0], 32'h0);
    chk("rst_if_ready", 0, 32'(d_rdy[0]), 32'h1);
    chk("rst_flush_cnt", 0, 32'(d_cnt[0]), 32'h0);
    tick();
    rst_n = 1'b1;

    // First instruction: lw opcode 0x23.
    if_valid = 1'b1; id_ready = 1'b1; flush = 1'b0;
    if_instr = 32'h8C01_0004; if_pc = 32'h0000_0004;
    tick();
    if_valid = 1'b0;
    @(negedge clk);
    chk("first_id_valid", 0, 32'(d_vld[0]), 32'h1);
    chk("first_opcode", 0, 32'(d_op[0]), 32'h23);
    chk("first_instr", 0, d_ins[0], 32'h8C01_0004);
    chk("first_pc", 0, d_pc[0], 32'h0000_0004);

    // Back-to-back streaming.
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 1'b1, 1'b0);
      tick();
    end
    drive(1'b0, 1'b1, 1'b0);
    tick();

    // Stall with the decoder blocked: skid fills, no-skid build back-pressures at once.
    drive(1'b1, 1'b0, 1'b0);
    stall_first = if_instr;
    tick();
    drive(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("stall1_if_ready", 0, 32'(d_rdy[0]), 32'h1);
    chk("stall1_if_ready", 1, 32'(d_rdy[1]), 32'h0);
    tick();
    drive(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("stall2_if_ready", 0, 32'(d_rdy[0]), 32'h0);
    chk("stall2_head", 0, d_ins[0], stall_first);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b1, 1'b0);
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1, 1'b0);
      tick();
    end

    // Fill M and S, then flush with fetch still presenting an instruction.
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("flush_id_valid", 0, 32'(d_vld[0]), 32'h0);
    chk("flush_id_instr", 0, d_ins[0], 32'h0);
    chk("flush_cnt_full", 0, 32'(d_cnt[0]), 32'd2);
    chk("flush_if_ready", 0, 32'(d_rdy[0]), 32'h1);
    chk("flush_cnt_single", 1, 32'(d_cnt[1]), 32'd1);

    // Five flushes each discarding one accepted instruction.
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b0, 1'b1);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("flush_cnt_sat", 2, 32'(d_cnt[2]), 32'd3);
    chk("flush_cnt_wide", 0, 32'(d_cnt[0]), 32'd7);
    chk("flush_cnt_wide", 1, 32'(d_cnt[1]), 32'd6);

    // No-skid build: drain and accept in the same cycle without a bubble.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1, 1'b0);
      tick();
    end
    @(negedge clk);
    chk("noskid_stream_valid", 1, 32'(d_vld[1]), 32'h1);
    chk("noskid_stream_ready", 1, 32'(d_rdy[1]), 32'h1);
    tick();

    // Random traffic with one asynchronous reset pulse in the middle.
    for (int k = 0; k < 3000; k++) begin
      drive($urandom_range(9, 0) < 7, $urandom_range(9, 0) < 6, $urandom_range(19, 0) == 0);
      if (k == 1500) begin
        #2;
        rst_n = 1'b0;
        model_reset();
      end
      tick();
      if (k == 1500) rst_n = 1'b1;
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
